// File: rtl/bar_meter_ctrl.sv
// Peak-hold / decay controller for an 8-LED thermometer bar decoder.
// Accepts 4-bit samples, holds the displayed peak for HOLD_TICKS, then decays one step per DECAY_TICKS.
module bar_meter_ctrl #(
  parameter int TICK_DIV    = 1000000,
  parameter int HOLD_TICKS  = 50,
  parameter int DECAY_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [3:0] sample,
  output logic       sample_ready,
  output logic [3:0] level,
  output logic [3:0] peak,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    DECAY = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      level_q, level_d;
  logic [3:0]      peak_q,  peak_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic [DW-1:0]   decay_q, decay_d;

  logic accept;
  logic capture;
  logic tick;

  assign sample_ready = enable & ~clear;
  assign accept       = sample_valid & sample_ready;
  assign capture      = accept & (sample >= level_q) & (sample != 4'd0);
  assign tick         = sample_ready & (presc_q == PW'(TICK_DIV - 1));

  // NOTE: every *_d gets its current value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    presc_d = (!sample_ready || tick) ? '0 : presc_q + PW'(1);

    if (clear) begin
      state_d = IDLE;
      level_d = 4'd0;
      peak_d  = 4'd0;
      hold_d  = '0;
      decay_d = '0;
    end else if (enable) begin
      if (accept && (sample > peak_q)) peak_d = sample;

      // A capture re-arms the hold and takes precedence over a coincident tick.
      if (capture) begin
        level_d = sample;
        hold_d  = '0;
        decay_d = '0;
        state_d = HOLD;
      end else if (tick) begin
        unique case (state_q)
          IDLE: ;
          HOLD: begin
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
              state_d = DECAY;
              hold_d  = '0;
              decay_d = '0;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          DECAY: begin
            if (decay_q == DW'(DECAY_TICKS - 1)) begin
              decay_d = '0;
              if (level_q <= 4'd1) begin
                level_d = 4'd0;
                state_d = IDLE;
              end else begin
                level_d = level_q - 4'd1;
              end
            end else begin
              decay_d = decay_q + DW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= 4'd0;
      peak_q  <= 4'd0;
      presc_q <= '0;
      hold_q  <= '0;
      decay_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      peak_q  <= peak_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      decay_q <= decay_d;
    end
  end

  assign level = level_q;
  assign peak  = peak_q;
  assign state = state_q;

endmodule
